level_tracker: RTL and testbench

//  Holds the current Frogger level as two BCD digits and drives the two segment_display

---
 rtl/level_tracker_pkg.sv | 15 +
 rtl/level_tracker_bcd_counter_2d.sv | 61 ++++++
 rtl/level_tracker.sv | 161 ++++++++++++++++
 tb/tb_level_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/level_tracker_pkg.sv
// rtl/level_tracker_pkg.sv - shared game constants and FSM encoding for the level tracker
package level_tracker_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        CELEBRATE = 2'd1,
        OVER      = 2'd2
    } state_t;

    // The segment decoder renders this code as an unlit digit
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    localparam int CLK_HZ = 25_000_000;

endpackage

// File: rtl/level_tracker_bcd_counter_2d.sv
// rtl/level_tracker_bcd_counter_2d.sv - two-digit BCD level counter with load and saturation
module bcd_counter_2d #(
    parameter int START_LEVEL = 1,
    parameter int MAX_LEVEL   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] nxt_ones,
    output logic [3:0] nxt_tens,
    output logic [6:0] bin,
    output logic       at_max
);

    localparam logic [3:0] START_ONES = 4'(START_LEVEL % 10);
    localparam logic [3:0] START_TENS = 4'(START_LEVEL / 10);
    localparam logic [3:0] MAX_ONES   = 4'(MAX_LEVEL % 10);
    localparam logic [3:0] MAX_TENS   = 4'(MAX_LEVEL / 10);
    localparam logic [6:0] START_BIN  = 7'(START_LEVEL);
    localparam logic       START_MAX  = (START_LEVEL == MAX_LEVEL);

    logic nxt_at_max;

    // Next digits: load wins, increments saturate at MAX_LEVEL and never push tens past 9.
    // Exposed so the parent can register its display mux from the same next value.
    always_comb begin
        nxt_ones = ones;
        nxt_tens = tens;
        if (load) begin
            nxt_ones = START_ONES;
            nxt_tens = START_TENS;
        end else if (inc && !at_max && !(tens == 4'd9 && ones == 4'd9)) begin
            if (ones == 4'd9) begin
                nxt_ones = 4'd0;
                nxt_tens = tens + 4'd1;
            end else begin
                nxt_ones = ones + 4'd1;
            end
        end
        nxt_at_max = (nxt_ones == MAX_ONES) && (nxt_tens == MAX_TENS);
    end

    // Digits, binary copy and max flag are all registered together so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones   <= START_ONES;
            tens   <= START_TENS;
            bin    <= START_BIN;
            at_max <= START_MAX;
        end else begin
            ones   <= nxt_ones;
            tens   <= nxt_tens;
            bin    <= ({3'd0, nxt_tens} * 7'd10) + {3'd0, nxt_ones};
            at_max <= nxt_at_max;
        end
    end

endmodule

// File: rtl/level_tracker.sv
// rtl/level_tracker.sv - level FSM, blink timer and blanking mux driving two digit decoders
module level_tracker
    import level_tracker_pkg::*;
#(
    parameter int START_LEVEL       = 1,
    parameter int MAX_LEVEL         = 99,
    parameter int BLINK_HALF_CYCLES = 6_250_000,
    parameter int BLINK_COUNT       = 3,
    parameter bit BLANK_LEADING     = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Level_Up,
    input  logic       i_Game_Over,
    input  logic       i_Restart,
    output logic [3:0] o_Level_Ones,
    output logic [3:0] o_Level_Tens,
    output logic [6:0] o_Level_Bin,
    output logic       o_Max_Reached,
    output logic       o_Busy
);

    localparam int PW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam int CW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT + 1) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(BLINK_HALF_CYCLES - 1);
    localparam logic [CW-1:0] PAIR_LAST = CW'(BLINK_COUNT - 1);

    localparam logic [3:0] RST_ONES = 4'(START_LEVEL % 10);
    localparam logic [3:0] RST_TENS = (BLANK_LEADING && (START_LEVEL / 10) == 0)
                                      ? BLANK_DIGIT : 4'(START_LEVEL / 10);

    state_t        state, state_n;
    logic          phase_on, phase_on_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [CW-1:0] pair, pair_n;
    logic          inc, load;
    logic          at_max;
    logic [3:0]    cur_ones, cur_tens, nxt_ones, nxt_tens;
    logic          blank_all;
    logic [3:0]    disp_ones, disp_tens;

    bcd_counter_2d #(
        .START_LEVEL(START_LEVEL),
        .MAX_LEVEL  (MAX_LEVEL)
    ) u_counter (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .inc     (inc),
        .load    (load),
        .ones    (cur_ones),
        .tens    (cur_tens),
        .nxt_ones(nxt_ones),
        .nxt_tens(nxt_tens),
        .bin     (o_Level_Bin),
        .at_max  (at_max)
    );

    // Next-state and blink timing; restart beats game-over beats level-up
    always_comb begin
        state_n    = state;
        phase_on_n = phase_on;
        pcnt_n     = pcnt;
        pair_n     = pair;
        inc        = 1'b0;
        load       = 1'b0;
        if (i_Restart) begin
            load       = 1'b1;
            state_n    = PLAY;
            phase_on_n = 1'b0;
            pcnt_n     = '0;
            pair_n     = '0;
        end else if (i_Game_Over) begin
            state_n    = OVER;
            phase_on_n = 1'b0;
            pcnt_n     = '0;
            pair_n     = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (i_Level_Up && !at_max) begin
                        inc        = 1'b1;
                        state_n    = CELEBRATE;
                        phase_on_n = 1'b0;
                        pcnt_n     = '0;
                        pair_n     = '0;
                    end
                end
                CELEBRATE: begin
                    if (i_Level_Up && !at_max) begin
                        inc        = 1'b1;
                        phase_on_n = 1'b0;
                        pcnt_n     = '0;
                        pair_n     = '0;
                    end else if (pcnt == PCNT_LAST) begin
                        pcnt_n = '0;
                        if (!phase_on) begin
                            phase_on_n = 1'b1;
                        end else if (pair == PAIR_LAST) begin
                            state_n    = PLAY;
                            phase_on_n = 1'b0;
                            pair_n     = '0;
                        end else begin
                            phase_on_n = 1'b0;
                            pair_n     = pair + 1'b1;
                        end
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end
                OVER: begin
                    if (pcnt == PCNT_LAST) begin
                        pcnt_n     = '0;
                        phase_on_n = !phase_on;
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end
                default: begin
                    state_n = PLAY;
                    pcnt_n  = '0;
                    pair_n  = '0;
                end
            endcase
        end
    end

    // Display mux computed from next values so digits move one clock after the pulse
    always_comb begin
        blank_all = (state_n != PLAY) && !phase_on_n;
        disp_ones = blank_all ? BLANK_DIGIT : nxt_ones;
        if (blank_all || (BLANK_LEADING && nxt_tens == 4'd0)) begin
            disp_tens = BLANK_DIGIT;
        end else begin
            disp_tens = nxt_tens;
        end
    end

    // FSM, blink counters and registered display outputs
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= PLAY;
            phase_on     <= 1'b0;
            pcnt         <= '0;
            pair         <= '0;
            o_Level_Ones <= RST_ONES;
            o_Level_Tens <= RST_TENS;
            o_Busy       <= 1'b0;
        end else begin
            state        <= state_n;
            phase_on     <= phase_on_n;
            pcnt         <= pcnt_n;
            pair         <= pair_n;
            o_Level_Ones <= disp_ones;
            o_Level_Tens <= disp_tens;
            o_Busy       <= (state_n == CELEBRATE);
        end
    end

    assign o_Max_Reached = at_max;

endmodule

// File: tb/tb_level_tracker.sv
// tb/tb_level_tracker.sv - scoreboard bench for level_tracker with short blink timing
module tb_level_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0;
    logic       go = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] ones, tens;
    logic [6:0] bin;
    logic       mx, busy;

    typedef struct {
        int         cyc;
        logic [3:0] ones;
        logic [3:0] tens;
        logic [6:0] bin;
        logic       busy;
        logic       mx;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;

    level_tracker #(
        .START_LEVEL      (1),
        .MAX_LEVEL        (99),
        .BLINK_HALF_CYCLES(4),
        .BLINK_COUNT      (2),
        .BLANK_LEADING    (1'b1)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Level_Up   (up),
        .i_Game_Over  (go),
        .i_Restart    (rs),
        .o_Level_Ones (ones),
        .o_Level_Tens (tens),
        .o_Level_Bin  (bin),
        .o_Max_Reached(mx),
        .o_Busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_chk++;
            if (e.cyc < cyc) begin
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (ones === e.ones && tens === e.tens && bin === e.bin &&
                         busy === e.busy && mx === e.mx) begin
                n_pass++;
            end else begin
                $display("FAIL %s cyc %0d: got ones=%h tens=%h bin=%0d busy=%b max=%b, expected ones=%h tens=%h bin=%0d busy=%b max=%b",
                         e.name, cyc, ones, tens, bin, busy, mx,
                         e.ones, e.tens, e.bin, e.busy, e.mx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int off, input logic [3:0] o, input logic [3:0] t,
                             input logic [6:0] b, input logic bz, input logic m,
                             input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.ones = o;
        e.tens = t;
        e.bin  = b;
        e.busy = bz;
        e.mx   = m;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // mask bits: [2]=restart [1]=game_over [0]=level_up; leaves time just after the sampling edge
    task automatic pulse(input logic [2:0] mask);
        rs = mask[2];
        go = mask[1];
        up = mask[0];
        tick();
        rs = 1'b0;
        go = 1'b0;
        up = 1'b0;
    endtask

    // level 1 -> 2 with a full 2-pair blink of 4-clock phases, then steady
    task automatic first_level_up(input string tag);
        pulse(3'b001);
        for (int k = 0; k < 18; k++) begin
            if (k >= 16)
                expect_at(k, 4'd2, 4'hF, 7'd2, 1'b0, 1'b0, {tag, "_steady"});
            else if (((k / 4) % 2) == 0)
                expect_at(k, 4'hF, 4'hF, 7'd2, 1'b1, 1'b0, {tag, "_off"});
            else
                expect_at(k, 4'd2, 4'hF, 7'd2, 1'b1, 1'b0, {tag, "_on"});
        end
        repeat (18) tick();
    endtask

    initial begin
        // 1. reset and idle
        tick();
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "reset_hold");
        tick();
        rst = 1'b0;
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "reset_release");
        repeat (10) tick();
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "idle10");
        tick();

        // 2. single level-up blink sequence
        first_level_up("lvl2");

        // 3. climb to 9, then carry into tens
        repeat (7) pulse(3'b001);
        expect_at(0, 4'hF, 4'hF, 7'd9, 1'b1, 1'b0, "lvl9_blank");
        pulse(3'b001);
        expect_at(0, 4'hF, 4'hF, 7'd10, 1'b1, 1'b0, "carry_blank");
        expect_at(16, 4'd0, 4'd1, 7'd10, 1'b0, 1'b0, "carry_steady");
        repeat (17) tick();

        // 4. climb to 99 and saturate
        repeat (89) pulse(3'b001);
        expect_at(0, 4'hF, 4'hF, 7'd99, 1'b1, 1'b1, "lvl99_blank");
        expect_at(16, 4'd9, 4'd9, 7'd99, 1'b0, 1'b1, "lvl99_steady");
        repeat (17) tick();
        pulse(3'b001);
        expect_at(0, 4'd9, 4'd9, 7'd99, 1'b0, 1'b1, "max_ignore");
        expect_at(5, 4'd9, 4'd9, 7'd99, 1'b0, 1'b1, "max_no_blink");
        repeat (6) tick();

        // 5. game over beats level-up in CELEBRATE, then restart
        pulse(3'b100);
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "restart_from_max");
        tick();
        pulse(3'b001);
        expect_at(0, 4'hF, 4'hF, 7'd2, 1'b1, 1'b0, "celebrate_entry");
        repeat (2) tick();
        pulse(3'b011);
        for (int k = 0; k < 14; k++) begin
            if (((k / 4) % 2) == 0)
                expect_at(k, 4'hF, 4'hF, 7'd2, 1'b0, 1'b0, "over_off");
            else
                expect_at(k, 4'd2, 4'hF, 7'd2, 1'b0, 1'b0, "over_on");
        end
        repeat (14) tick();
        pulse(3'b001);
        expect_at(0, 4'd2, 4'hF, 7'd2, 1'b0, 1'b0, "over_ignore_up");
        pulse(3'b100);
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "restart");
        expect_at(6, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "restart_steady");
        repeat (7) tick();

        // 6. async reset mid-CELEBRATE, then level-up works as before
        pulse(3'b001);
        expect_at(0, 4'hF, 4'hF, 7'd2, 1'b1, 1'b0, "pre_reset_celebrate");
        repeat (2) tick();
        #2;
        rst = 1'b1;
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "async_reset");
        tick();
        rst = 1'b0;
        expect_at(0, 4'd1, 4'hF, 7'd1, 1'b0, 1'b0, "after_reset");
        tick();
        first_level_up("post_rst");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && sbq.size() > 0; i++) tick();
        if (sbq.size() > 0) begin
            $display("FAIL drain: %0d expectations never sampled, required 0", sbq.size());
            n_chk += sbq.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
